// File: rtl/arc4_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arc4_ctrl
// Description : Top-level sequencer for the ARC4 decryption datapath.
//               A single accepted start request runs the init, ksa and prga
//               engines in that order, each through its own en/rdy
//               handshake. The controller owns the single-port S memory and
//               routes the write/address port to whichever engine is
//               currently active. The key is latched on acceptance so the
//               engines see a stable value for the whole run.
//
// Ports       :
//   clk                     system clock, rising-edge active
//   rst_n                   asynchronous active-low reset
//   en / rdy                start request / idle-and-ready
//   key / key_q             key input / key latched on acceptance
//   init_en, ksa_en,
//   prga_en                 one-cycle start pulses to the engines
//   init_rdy, ksa_rdy,
//   prga_rdy                engine ready inputs
//   <eng>_addr, <eng>_wrdata,
//   <eng>_wren              per-engine S-port requests
//   s_addr, s_wrdata, s_wren
//                           S memory port (driven by the owning engine)
//   err                     sticky: a non-owner engine asserted wren
//
// Revision    : 1.0 - initial release
// ============================================================================
module arc4_ctrl #(
    parameter int KEYLEN = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  en,
    output logic                  rdy,
    input  logic [8*KEYLEN-1:0]   key,
    output logic [8*KEYLEN-1:0]   key_q,

    output logic                  init_en,
    output logic                  ksa_en,
    output logic                  prga_en,
    input  logic                  init_rdy,
    input  logic                  ksa_rdy,
    input  logic                  prga_rdy,

    input  logic [7:0]            init_addr,
    input  logic [7:0]            init_wrdata,
    input  logic                  init_wren,
    input  logic [7:0]            ksa_addr,
    input  logic [7:0]            ksa_wrdata,
    input  logic                  ksa_wren,
    input  logic [7:0]            prga_addr,
    input  logic [7:0]            prga_wrdata,
    input  logic                  prga_wren,

    output logic [7:0]            s_addr,
    output logic [7:0]            s_wrdata,
    output logic                  s_wren,
    output logic                  err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_START_INIT = 3'd1;
    localparam logic [2:0] c_WAIT_INIT  = 3'd2;
    localparam logic [2:0] c_START_KSA  = 3'd3;
    localparam logic [2:0] c_WAIT_KSA   = 3'd4;
    localparam logic [2:0] c_START_PRGA = 3'd5;
    localparam logic [2:0] c_WAIT_PRGA  = 3'd6;

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic                   r_seen_busy;
    logic                   w_seen_busy_nxt;
    logic [8*KEYLEN-1:0]    r_key_q;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_own_init;
    logic                   w_own_ksa;
    logic                   w_own_prga;
    logic                   w_nonowner_wren;

    // ------------------------------------------------------------------------
    // Ownership decode: an engine owns the S port from the first cycle of its
    // START state until the edge that leaves its WAIT state.
    // ------------------------------------------------------------------------
    assign w_accept   = (r_state == c_IDLE) && en;
    assign w_own_init = (r_state == c_START_INIT) || (r_state == c_WAIT_INIT);
    assign w_own_ksa  = (r_state == c_START_KSA)  || (r_state == c_WAIT_KSA);
    assign w_own_prga = (r_state == c_START_PRGA) || (r_state == c_WAIT_PRGA);

    // In IDLE nobody owns the port, so any write request there is flagged.
    assign w_nonowner_wren = (init_wren && !w_own_init) ||
                             (ksa_wren  && !w_own_ksa)  ||
                             (prga_wren && !w_own_prga);

    // ------------------------------------------------------------------------
    // Next-state logic
    //
    // seen_busy is forced low in every non-WAIT state, which clears it on
    // entry to WAIT. Inside WAIT it latches any cycle with the engine's rdy
    // low, so an engine whose rdy drops a cycle or two late cannot be
    // mistaken for one that has already finished.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_seen_busy_nxt = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (en) begin
                    w_state_nxt = c_START_INIT;
                end
            end
            c_START_INIT: begin
                if (init_rdy) begin
                    w_state_nxt = c_WAIT_INIT;
                end
            end
            c_WAIT_INIT: begin
                w_seen_busy_nxt = r_seen_busy | ~init_rdy;
                if (init_rdy && r_seen_busy) begin
                    w_state_nxt = c_START_KSA;
                end
            end
            c_START_KSA: begin
                if (ksa_rdy) begin
                    w_state_nxt = c_WAIT_KSA;
                end
            end
            c_WAIT_KSA: begin
                w_seen_busy_nxt = r_seen_busy | ~ksa_rdy;
                if (ksa_rdy && r_seen_busy) begin
                    w_state_nxt = c_START_PRGA;
                end
            end
            c_START_PRGA: begin
                if (prga_rdy) begin
                    w_state_nxt = c_WAIT_PRGA;
                end
            end
            c_WAIT_PRGA: begin
                w_seen_busy_nxt = r_seen_busy | ~prga_rdy;
                if (prga_rdy && r_seen_busy) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                // Unused encoding: recover to IDLE.
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_seen_busy <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_seen_busy <= w_seen_busy_nxt;
        end
    end

    // Key is captured only on the accepting edge; later key changes are
    // invisible to the engines until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_q <= '0;
        end else if (w_accept) begin
            r_key_q <= key;
        end
    end

    // Sticky error: a new run starts clean; a stray write from a non-owner
    // engine on any later edge sets it until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_nonowner_wren) begin
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    //
    // Start pulses are decoded from the START state and the engine's rdy, so
    // each is high for exactly the single cycle spent in START with the
    // engine ready, and an asynchronous reset drops them immediately.
    // ------------------------------------------------------------------------
    assign rdy     = (r_state == c_IDLE);
    assign init_en = (r_state == c_START_INIT) && init_rdy;
    assign ksa_en  = (r_state == c_START_KSA)  && ksa_rdy;
    assign prga_en = (r_state == c_START_PRGA) && prga_rdy;
    assign key_q   = r_key_q;
    assign err     = r_err;

    // S-port mux: only the owning engine reaches the memory.
    always_comb begin
        s_addr   = 8'h00;
        s_wrdata = 8'h00;
        s_wren   = 1'b0;
        if (w_own_init) begin
            s_addr   = init_addr;
            s_wrdata = init_wrdata;
            s_wren   = init_wren;
        end else if (w_own_ksa) begin
            s_addr   = ksa_addr;
            s_wrdata = ksa_wrdata;
            s_wren   = ksa_wren;
        end else if (w_own_prga) begin
            s_addr   = prga_addr;
            s_wrdata = prga_wrdata;
            s_wren   = prga_wren;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arc4_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_arc4_ctrl
// Description : Self-checking bench for arc4_ctrl. Three stub engines with
//               configurable busy length and late-rdy delay drive the S-port
//               request lines; the expected S writes of each run are pushed
//               to a scoreboard queue when the run is started and popped as
//               the controller forwards writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arc4_ctrl;

    localparam int KEYLEN = 3;
    localparam int KW     = 8 * KEYLEN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stub_rst_n = 1'b0;
    logic          en = 1'b0;
    logic          rdy;
    logic [KW-1:0] key = '0;
    logic [KW-1:0] key_q;
    logic          init_en, ksa_en, prga_en;
    logic          init_rdy, ksa_rdy, prga_rdy;
    logic [7:0]    init_addr, init_wrdata, ksa_addr, ksa_wrdata;
    logic [7:0]    prga_addr, prga_wrdata;
    logic          init_wren, ksa_wren, prga_wren;
    logic [7:0]    s_addr, s_wrdata;
    logic          s_wren;
    logic          err;

    always #5 clk = ~clk;

    arc4_ctrl #(.KEYLEN(KEYLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .en(en), .rdy(rdy), .key(key), .key_q(key_q),
        .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
        .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
        .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
        .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
        .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .err(err)
    );

    // ------------------------------------------------------------------------
    // Stub engines (index 0=init, 1=ksa, 2=prga). After en: rdy stays 1 for
    // late[i] cycles, then is 0 for len[i] cycles while writing, then 1.
    // ------------------------------------------------------------------------
    int         len  [3];
    int         late [3];
    bit         active [3];
    int         cnt  [3];
    logic [2:0] eng_en;
    logic [2:0] busy;
    logic [7:0] idx [3];
    bit         inj = 1'b0;

    assign eng_en = {prga_en, ksa_en, init_en};

    always @(posedge clk or negedge stub_rst_n) begin
        if (!stub_rst_n) begin
            for (int i = 0; i < 3; i++) begin
                active[i] <= 1'b0;
                cnt[i]    <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!active[i]) begin
                    if (eng_en[i]) begin
                        active[i] <= 1'b1;
                        cnt[i]    <= 0;
                    end
                end else begin
                    if (cnt[i] == late[i] + len[i] - 1) active[i] <= 1'b0;
                    cnt[i] <= cnt[i] + 1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            busy[i] = active[i] && (cnt[i] >= late[i]);
            idx[i]  = 8'(cnt[i] - late[i]);
        end
        init_rdy    = ~busy[0];
        init_wren   = busy[0];
        init_addr   = idx[0];
        init_wrdata = idx[0];
        ksa_rdy     = ~busy[1];
        ksa_wren    = busy[1] | inj;
        ksa_addr    = inj ? 8'hEE : idx[1];
        ksa_wrdata  = inj ? 8'hEE : ~idx[1];
        prga_rdy    = ~busy[2];
        prga_wren   = busy[2];
        prga_addr   = idx[2] ^ 8'h5A;
        prga_wrdata = idx[2] + 8'h11;
    end

    // ------------------------------------------------------------------------
    // Bench state
    // ------------------------------------------------------------------------
    int          errors = 0;
    int          checks = 0;
    logic [15:0] sb_q [$];
    int          en_log [$];
    logic [2:0]  prev_en = 3'b000;
    bit          run_active = 1'b0;
    int          run_ticks = 0;
    logic [KW-1:0] exp_key = '0;

    // One clock: sample #1 after the edge, consume the scoreboard, log start
    // pulses and confirm key_q stays at the accepted key during a run.
    task automatic tick();
        logic [15:0] exp;
        logic [2:0]  cur;
        @(posedge clk);
        #1;
        if (run_active) run_ticks++;
        if (s_wren === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write: got addr=%02h data=%02h, expected no write",
                         s_addr, s_wrdata);
            end else begin
                exp = sb_q.pop_front();
                if ({s_addr, s_wrdata} !== exp) begin
                    errors++;
                    $display("FAIL sb_write: got addr/data=%04h expected %04h", {s_addr, s_wrdata}, exp);
                end
            end
        end
        cur = eng_en;
        for (int i = 0; i < 3; i++) begin
            if (cur[i]) begin
                en_log.push_back(i);
                checks++;
                if (prev_en[i]) begin
                    errors++;
                    $display("FAIL en_width: engine %0d en high for 2+ cycles, expected 1", i);
                end
            end
        end
        prev_en = cur;
        if (run_active) begin
            checks++;
            if (key_q !== exp_key) begin
                errors++;
                $display("FAIL key_q_stable: got %06h expected %06h", key_q, exp_key);
            end
        end
    endtask

    task automatic start_run(input logic [KW-1:0] k,
                             input int l0, input int l1, input int l2,
                             input int t0, input int t1, input int t2);
        logic [7:0] b;
        len[0] = l0; len[1] = l1; len[2] = l2;
        late[0] = t0; late[1] = t1; late[2] = t2;
        for (int i = 0; i < l0; i++) begin b = 8'(i); sb_q.push_back({b, b}); end
        for (int i = 0; i < l1; i++) begin b = 8'(i); sb_q.push_back({b, ~b}); end
        for (int i = 0; i < l2; i++) begin b = 8'(i); sb_q.push_back({b ^ 8'h5A, b + 8'h11}); end
        en_log.delete();
        en = 1'b1;
        key = k;
        exp_key = k;
        tick();
        en = 1'b0;
        run_active = 1'b1;
        run_ticks = 0;
        checks++;
        if (rdy !== 1'b0 || init_en !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL start_seq: got rdy=%b init_en=%b err=%b expected rdy=0 init_en=1 err=0",
                     rdy, init_en, err);
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (rdy !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        run_active = 1'b0;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL run_timeout: rdy=%b after %0d cycles, expected 1", rdy, budget);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        stub_rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        stub_rst_n = 1'b1;
        #1;
        checks++;
        if (rdy !== 1'b1 || {init_en, ksa_en, prga_en} !== 3'b000 || s_wren !== 1'b0 ||
            err !== 1'b0 || key_q !== '0 || s_addr !== 8'h00 || s_wrdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: rdy=%b en=%b s_wren=%b err=%b key_q=%06h s=%02h/%02h expected 1,000,0,0,0,00/00",
                     rdy, {init_en, ksa_en, prga_en}, s_wren, err, key_q, s_addr, s_wrdata);
        end
        tick();
        checks++;
        if (rdy !== 1'b1 || {init_en, ksa_en, prga_en} !== 3'b000) begin
            errors++;
            $display("FAIL idle_hold: rdy=%b en=%b expected 1,000", rdy, {init_en, ksa_en, prga_en});
        end
    endtask

    task automatic test_full_run();
        start_run(24'h00033C, 256, 768, 10, 0, 0, 0);
        wait_done(3000);
        checks++;
        if (run_ticks != 1040) begin
            errors++;
            $display("FAIL full_cycles: got %0d expected 1040", run_ticks);
        end
        checks++;
        if (en_log.size() != 3 || en_log[0] != 0 || en_log[1] != 1 || en_log[2] != 2) begin
            errors++;
            $display("FAIL full_order: got %0d pulses, expected init,ksa,prga once each", en_log.size());
        end
        checks++;
        if (sb_q.size() != 0 || err !== 1'b0 || key_q !== 24'h00033C) begin
            errors++;
            $display("FAIL full_end: pending=%0d err=%b key_q=%06h expected 0,0,00033c",
                     sb_q.size(), err, key_q);
        end
    endtask

    task automatic test_ownership();
        start_run(24'h0A0B0C, 256, 8, 4, 0, 0, 0);
        repeat (50) tick();
        inj = 1'b1;
        repeat (2) tick();
        inj = 1'b0;
        tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got err=%b expected 1", err);
        end
        wait_done(3000);
        checks++;
        if (run_ticks != 274 || sb_q.size() != 0 || en_log.size() != 3) begin
            errors++;
            $display("FAIL own_run: cycles=%0d pending=%0d pulses=%0d expected 274,0,3",
                     run_ticks, sb_q.size(), en_log.size());
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got err=%b expected 1", err);
        end
    endtask

    task automatic test_late_rdy();
        // start_run also confirms err was cleared by this accepted start.
        start_run(24'h112233, 4, 6, 3, 1, 2, 0);
        wait_done(500);
        checks++;
        if (run_ticks != 22) begin
            errors++;
            $display("FAIL late_cycles: got %0d expected 22", run_ticks);
        end
        checks++;
        if (en_log.size() != 3 || en_log[0] != 0 || en_log[1] != 1 || en_log[2] != 2 ||
            sb_q.size() != 0) begin
            errors++;
            $display("FAIL late_order: pulses=%0d pending=%0d expected 3,0", en_log.size(), sb_q.size());
        end
    endtask

    task automatic test_busy_ignore();
        start_run(24'h123456, 20, 30, 5, 0, 0, 0);
        repeat (25) tick();
        en = 1'b1;
        key = 24'hFFFFFF;
        repeat (3) tick();
        en = 1'b0;
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL busy_rdy: got rdy=%b expected 0", rdy);
        end
        wait_done(500);
        checks++;
        if (run_ticks != 61 || en_log.size() != 3 || key_q !== 24'h123456) begin
            errors++;
            $display("FAIL busy_run: cycles=%0d pulses=%0d key_q=%06h expected 61,3,123456",
                     run_ticks, en_log.size(), key_q);
        end
    endtask

    task automatic test_back_to_back();
        // Called in the cycle where rdy has just returned to 1.
        start_run(24'h0000AA, 3, 3, 3, 0, 0, 0);
        wait_done(500);
        checks++;
        if (run_ticks != 15 || en_log.size() != 3 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_run: cycles=%0d pulses=%0d pending=%0d expected 15,3,0",
                     run_ticks, en_log.size(), sb_q.size());
        end
    endtask

    task automatic test_reset_midrun();
        start_run(24'h555555, 20, 30, 5, 0, 0, 0);
        repeat (25) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdy !== 1'b1 || ksa_en !== 1'b0 || s_wren !== 1'b0 || err !== 1'b0 || key_q !== '0) begin
            errors++;
            $display("FAIL midrun_reset: rdy=%b ksa_en=%b s_wren=%b err=%b key_q=%06h expected 1,0,0,0,0",
                     rdy, ksa_en, s_wren, err, key_q);
        end
        run_active = 1'b0;
        sb_q.delete();
        stub_rst_n = 1'b0;
        #1;
        stub_rst_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        start_run(24'h777777, 5, 5, 5, 0, 0, 0);
        wait_done(500);
        checks++;
        if (run_ticks != 21 || en_log.size() != 3 || en_log[0] != 0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL restart_run: cycles=%0d pulses=%0d pending=%0d expected 21,3,0",
                     run_ticks, en_log.size(), sb_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            len[i] = 1;
            late[i] = 0;
        end
        test_reset();
        test_full_run();
        test_ownership();
        test_late_rdy();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arc4_ctrl.md
# arc4_ctrl

Top-level sequencer for the ARC4 decryption datapath. On a single start request it runs the three engines `init`, `ksa` and `prga` in order, each through its own en/rdy handshake. It also owns the single-port S memory and multiplexes its write/address port to whichever engine is currently active. It sits between the task-level wrapper and the three engines, and it latches the key so that the engines see a stable value for the whole run.

## Interface
Parameters:
- KEYLEN, 3: key length in bytes; key width is 8*KEYLEN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  start request; accepted only when rdy=1.
- rdy  out  1  1 = idle and able to accept en.
- key  in  8*KEYLEN  key; sampled on the accepting edge.
- key_q  out  8*KEYLEN  latched key, routed to ksa/prga.
- init_en, ksa_en, prga_en  out  1 each  one-cycle start pulses to the engines.
- init_rdy, ksa_rdy, prga_rdy  in  1 each  engine ready signals.
- init_addr, init_wrdata  in  8 each  init S-port request.
- init_wren  in  1  init S-port write enable.
- ksa_addr, ksa_wrdata  in  8 each  ksa S-port request.
- ksa_wren  in  1  ksa S-port write enable.
- prga_addr, prga_wrdata  in  8 each  prga S-port request.
- prga_wren  in  1  prga S-port write enable.
- s_addr, s_wrdata  out  8 each  S memory port.
- s_wren  out  1  S memory write enable.
- err  out  1  sticky: a non-owner engine asserted wren.

## Operation
- States: IDLE, START_INIT, WAIT_INIT, START_KSA, WAIT_KSA, START_PRGA, WAIT_PRGA.
- IDLE
  - rdy=1.
  - en=1 → latch key into key_q, clear err, go to START_INIT.
- START_x
  - If x_rdy=1: drive x_en=1 for exactly this cycle, then go to WAIT_x.
  - If x_rdy=0: hold in START_x with x_en=0.
- WAIT_x
  - A local seen_busy flag is cleared on entry and set when x_rdy=0 is sampled.
  - Exit when x_rdy=1 and seen_busy=1.
  - Exit order: WAIT_INIT→START_KSA, WAIT_KSA→START_PRGA, WAIT_PRGA→IDLE.
  - This guards against an engine whose rdy drops one cycle late.
- Owner mux (combinational from state):
  - Owner is init in START/WAIT_INIT, ksa in START/WAIT_KSA, prga in START/WAIT_PRGA.
  - s_addr, s_wrdata and s_wren come from the owner only.
  - In IDLE: s_addr=0, s_wrdata=0, s_wren=0.
- Non-owner wren is never forwarded. A non-owner wren=1 on any edge sets err, which stays set until the next accepted en.
- en while rdy=0 is ignored and does not queue.
- key changes after acceptance do not affect key_q.

## Timing
- Reset values: state=IDLE, rdy=1, init_en=ksa_en=prga_en=0, key_q=0, s_wren=0, s_addr=0, s_wrdata=0, err=0.
- Reset is asynchronous and may land in any state. It takes effect immediately, aborts the run and leaves no en pulse pending.
- Start sequence:
  - Edge N samples en=1 with rdy=1.
  - Cycle N+1: rdy=0, init_en=1 (given init_rdy=1).
  - Cycle N+2: WAIT_INIT.
- Per-stage overhead: 1 START cycle plus WAIT cycles. WAIT lasts until the edge that samples rdy back at 1.
- Stage handover: on the edge that leaves WAIT_x, ownership switches. The first cycle of START_y already routes engine y to the S port.
- Finish: rdy returns to 1 in the cycle after the edge that samples prga_rdy=1 in WAIT_PRGA. en may be accepted on that very next edge (back-to-back runs).
- x_en never lasts more than one cycle. It is never asserted outside START_x.

## Test plan
- **Reset/idle:** hold rst_n=0 for 1 cycle, release → rdy=1, all *_en=0, s_wren=0, err=0.
- **Full run:** use stub engines with busy times init 256, ksa 768, prga 10 cycles. Pulse en with key=24'h00033C.
  - Exactly one pulse each on init_en, ksa_en, prga_en, in that order.
  - key_q=24'h00033C throughout.
  - rdy returns to 1 after the prga stub finishes.
- **Ownership:** init stub writes addr=i, wrdata=i for i=0..255.
  - s_addr=s_wrdata=i and s_wren=1 on each of those cycles.
  - ksa_wren=1 injected during WAIT_INIT is not forwarded and sets err=1.
  - err clears on the next start.
- **Late rdy:** an engine whose rdy stays 1 for 2 cycles after en → controller stays in WAIT until rdy has dropped and risen; no early advance.
- **Busy/ignore:** en=1 during WAIT_KSA → no restart. Key change to 24'hFFFFFF mid-run leaves key_q unchanged.
- **Reset mid-run:** assert rst_n=0 during WAIT_KSA → immediately rdy=1, ksa_en=0, s_wren=0. A fresh en then starts at init again.
